// File: rtl/rd_arb_pkg.sv
// Shared constants and types for the DDR read-burst arbiter.
package rd_arb_pkg;
  localparam int BURST_LEN = 16;
  localparam int OUTST_MAX = 4;

  typedef enum logic {ST_IDLE, ST_CMD} state_t;

  localparam int ERR_NO_TAG = 0;
  localparam int ERR_LAST   = 1;
endpackage

// File: rtl/rd_tag_queue.sv
// Small FIFO of channel tags, one per burst in flight, in DDR issue order.
module rd_tag_queue
  import rd_arb_pkg::*;
#(
  parameter int DEPTH = OUTST_MAX,
  parameter int TAG_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [TAG_W-1:0] push_tag,
  input  logic             pop,
  output logic [TAG_W-1:0] head,
  output logic             empty,
  output logic             full
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][TAG_W-1:0] mem;
  logic [PW-1:0] wptr, rptr;
  logic [NW-1:0] count;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rptr];
  assign empty   = (count == '0);
  assign full    = (count == NW'(DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem   <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= push_tag;
        wptr      <= nxt(wptr);
      end
      if (do_pop) rptr <= nxt(rptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/rd_burst_arbiter.sv
// Round-robin, credit-gated read-burst scheduler sharing one DDR read port
// among NUM_CH prefetch FIFOs; returning beats are steered by an issue-order tag queue.
module rd_burst_arbiter #(
  parameter int NUM_CH     = 3,
  parameter int ADDR_W     = 28,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 512,
  parameter int BURST_LEN  = rd_arb_pkg::BURST_LEN,
  parameter int OUTST_MAX  = rd_arb_pkg::OUTST_MAX
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_CH-1:0]             ch_req,
  input  logic [NUM_CH-1:0][ADDR_W-1:0] ch_addr,
  output logic [NUM_CH-1:0]             ch_ack,
  input  logic [NUM_CH-1:0]             ch_pop,
  output logic                          ar_valid,
  input  logic                          ar_ready,
  output logic [ADDR_W-1:0]             ar_addr,
  output logic [7:0]                    ar_len,
  input  logic                          r_valid,
  input  logic                          r_last,
  input  logic [DATA_W-1:0]             r_data,
  output logic                          r_ready,
  output logic [NUM_CH-1:0]             fifo_wr_en,
  output logic [DATA_W-1:0]             fifo_wr_data,
  output logic [1:0]                    err
);
  import rd_arb_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  state_t                    state, state_nx;
  logic [NUM_CH-1:0][CW-1:0] credit, credit_nx;
  logic [NUM_CH-1:0]         elig;
  logic [TW-1:0]             rr_ptr, grant, pick, idx;
  logic                      pick_vld, hs;
  logic [CW:0]               sum;
  logic [TW-1:0]             q_head;
  logic                      q_empty, q_full;
  logic                      beat_ok, tag_pop;
  logic [BW-1:0]             beat_cnt;

  assign ar_len   = 8'(BURST_LEN - 1);
  assign r_ready  = 1'b1;
  assign ar_valid = (state == ST_CMD);
  assign hs       = ar_valid & ar_ready;
  assign beat_ok  = r_valid & ~q_empty;
  assign tag_pop  = beat_ok & r_last;

  // A channel acked this cycle still shows its old request; keep it out of arbitration.
  always_comb begin
    credit_nx = credit;
    elig      = '0;
    sum       = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      sum = {1'b0, credit[c]} + (CW+1)'(ch_pop[c]);
      if (hs && grant == TW'(c)) sum = sum - (CW+1)'(BURST_LEN);
      credit_nx[c] = (sum > (CW+1)'(FIFO_DEPTH)) ? CW'(FIFO_DEPTH) : sum[CW-1:0];
      elig[c]      = ch_req[c] & ~ch_ack[c] & (credit[c] >= CW'(BURST_LEN));
    end
  end

  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    idx      = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = TW'((int'(rr_ptr) + i) % NUM_CH);
      if (!pick_vld && elig[idx]) begin
        pick_vld = 1'b1;
        pick     = idx;
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (pick_vld && !q_full) state_nx = ST_CMD;
      ST_CMD:  if (ar_ready) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit  <= {NUM_CH{CW'(FIFO_DEPTH)}};
      ar_addr <= '0;
      grant   <= '0;
      rr_ptr  <= TW'(NUM_CH - 1);
      ch_ack  <= '0;
    end else begin
      credit <= credit_nx;
      ch_ack <= NUM_CH'(hs) << grant;
      if (state == ST_IDLE && state_nx == ST_CMD) begin
        grant   <= pick;
        ar_addr <= ch_addr[pick];
      end
      if (hs) rr_ptr <= grant;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_wr_en   <= '0;
      fifo_wr_data <= '0;
      beat_cnt     <= '0;
      err          <= '0;
    end else begin
      fifo_wr_en <= NUM_CH'(beat_ok) << q_head;
      if (beat_ok) begin
        fifo_wr_data <= r_data;
        if (r_last) begin
          beat_cnt <= '0;
          if (beat_cnt != BW'(BURST_LEN - 1)) err[ERR_LAST] <= 1'b1;
        end else begin
          beat_cnt <= beat_cnt + 1'b1;
        end
      end
      if (r_valid && q_empty) err[ERR_NO_TAG] <= 1'b1;
    end
  end

  rd_tag_queue #(.DEPTH(OUTST_MAX), .TAG_W(TW)) u_tagq (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (hs),
    .push_tag (grant),
    .pop      (tag_pop),
    .head     (q_head),
    .empty    (q_empty),
    .full     (q_full)
  );
endmodule

// File: tb/tb_rd_burst_arbiter.sv
// Directed bench for rd_burst_arbiter with a write-side scoreboard of expected beats.
module tb_rd_burst_arbiter;
  logic             clk = 1'b0;
  logic             rst_n;
  logic [2:0]       ch_req, ch_ack, ch_pop;
  logic [2:0][27:0] ch_addr;
  logic             ar_valid, ar_ready;
  logic [27:0]      ar_addr;
  logic [7:0]       ar_len;
  logic             r_valid, r_last, r_ready;
  logic [15:0]      r_data;
  logic [2:0]       fifo_wr_en;
  logic [15:0]      fifo_wr_data;
  logic [1:0]       err;

  typedef struct {
    logic [2:0]  en;
    logic [15:0] data;
  } exp_t;
  exp_t exp_q[$];

  int tests = 0;
  int fails = 0;
  int lat;

  always #5 clk = ~clk;

  rd_burst_arbiter dut (
    .clk(clk), .rst_n(rst_n), .ch_req(ch_req), .ch_addr(ch_addr), .ch_ack(ch_ack),
    .ch_pop(ch_pop), .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr),
    .ar_len(ar_len), .r_valid(r_valid), .r_last(r_last), .r_data(r_data),
    .r_ready(r_ready), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: sample at negedge, compare any pending write against the scoreboard.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("wr_en", 32'(fifo_wr_en), 32'(e.en));
      chk("wr_data", 32'(fifo_wr_data), 32'(e.data));
    end else if (fifo_wr_en !== 3'b000) begin
      chk("spurious_wr", 32'(fifo_wr_en), 32'h0);
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    ch_req = '0; ch_pop = '0; r_valid = 1'b0; r_last = 1'b0; ar_ready = 1'b1;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic issue(input int ch, input logic [27:0] addr, output int n);
    logic [2:0] oh;
    oh = 3'b001 << ch;
    n = 0;
    tick();
    while (ar_valid !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk("ar_valid", 32'(ar_valid), 32'h1);
    chk("ar_addr", 32'(ar_addr), 32'(addr));
    tick();
    chk("ch_ack", 32'(ch_ack), 32'(oh));
    chk("ar_valid_drop", 32'(ar_valid), 32'h0);
  endtask

  task automatic burst(input int ch, input int last);
    logic [2:0] oh;
    oh = 3'b001 << ch;
    for (int i = 0; i <= last; i++) begin
      tick();
      r_valid = 1'b1;
      r_last  = (i == last);
      r_data  = 16'($urandom);
      exp_q.push_back('{en: oh, data: r_data});
    end
    tick();
    r_valid = 1'b0;
    r_last  = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ch_addr = '0;
    r_data  = '0;
    apply_reset();

    // reset values
    chk("rst_ar_valid", 32'(ar_valid), 32'h0);
    chk("rst_ar_addr", 32'(ar_addr), 32'h0);
    chk("rst_ch_ack", 32'(ch_ack), 32'h0);
    chk("rst_wr_en", 32'(fifo_wr_en), 32'h0);
    chk("rst_wr_data", 32'(fifo_wr_data), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_r_ready", 32'(r_ready), 32'h1);
    chk("rst_ar_len", 32'(ar_len), 32'd15);
    chk("rst_credit", 32'(dut.credit[0]), 32'd512);

    // single request on ch1
    ch_addr[1] = 28'h100;
    ch_req = 3'b010;
    issue(1, 28'h100, lat);
    chk("t1_latency", 32'(lat), 32'd0);
    ch_req = '0;
    burst(1, 15);
    chk("t1_credit", 32'(dut.credit[1]), 32'd496);
    chk("t1_err", 32'(err), 32'h0);

    // round robin with all three requesting, four in flight max
    apply_reset();
    ch_addr = {28'h3000, 28'h2000, 28'h1000};
    ch_req = 3'b111;
    issue(0, 28'h1000, lat);
    issue(1, 28'h2000, lat);
    issue(2, 28'h3000, lat);
    issue(0, 28'h1000, lat);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("t2_max_outst", 32'(ar_valid), 32'h0);
    end
    burst(0, 15);
    issue(1, 28'h2000, lat);
    ch_req = '0;
    burst(1, 15);
    burst(2, 15);
    burst(0, 15);
    burst(1, 15);
    chk("t2_credit0", 32'(dut.credit[0]), 32'd480);
    chk("t2_credit2", 32'(dut.credit[2]), 32'd496);

    // ch2 without pops: 32 bursts exhaust its credit
    apply_reset();
    ch_addr[2] = 28'h8000;
    for (int b = 0; b < 32; b++) begin
      ch_req = 3'b100;
      issue(2, 28'h8000, lat);
      ch_req = '0;
      burst(2, 15);
    end
    chk("t3_credit_empty", 32'(dut.credit[2]), 32'd0);
    ch_req = 3'b100;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t3_stall", 32'(ar_valid), 32'h0);
    end
    for (int i = 0; i < 16; i++) begin
      tick();
      if (i > 0) chk("t3_no_early_issue", 32'(ar_valid), 32'h0);
      ch_pop = 3'b100;
    end
    tick();
    ch_pop = '0;
    chk("t3_credit16", 32'(dut.credit[2]), 32'd16);
    chk("t3_no_issue_yet", 32'(ar_valid), 32'h0);
    issue(2, 28'h8000, lat);
    chk("t3_refill_lat", 32'(lat), 32'd0);
    ch_req = '0;
    burst(2, 15);

    // ar_ready held low: command frozen, req drop ignored
    ar_ready = 1'b0;
    ch_addr[0] = 28'hABCDEF0;
    ch_req = 3'b001;
    tick();
    chk("t4_valid", 32'(ar_valid), 32'h1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t4_hold_valid", 32'(ar_valid), 32'h1);
      chk("t4_hold_addr", 32'(ar_addr), 32'hABCDEF0);
      chk("t4_no_ack", 32'(ch_ack), 32'h0);
      if (i == 3) begin
        ch_req = '0;
        ch_addr[0] = '0;
      end
    end
    ar_ready = 1'b1;
    tick();
    chk("t4_ack", 32'(ch_ack), 32'h1);
    chk("t4_valid_drop", 32'(ar_valid), 32'h0);
    burst(0, 15);
    chk("t4_err", 32'(err), 32'h0);

    // early r_last, then orphan beat
    ch_addr[1] = 28'h5500;
    ch_req = 3'b010;
    issue(1, 28'h5500, lat);
    ch_req = '0;
    burst(1, 9);
    chk("t5_err_last", 32'(err), 32'h2);
    ch_addr[0] = 28'h6600;
    ch_req = 3'b001;
    issue(0, 28'h6600, lat);
    ch_req = '0;
    burst(0, 15);
    chk("t5_err_keep", 32'(err), 32'h2);
    tick();
    r_valid = 1'b1;
    r_data  = 16'hDEAD;
    tick();
    r_valid = 1'b0;
    tick();
    chk("t5_orphan_wr", 32'(fifo_wr_en), 32'h0);
    chk("t5_err_both", 32'(err), 32'h3);

    // reset in the middle of a burst
    apply_reset();
    ch_addr[2] = 28'h7700;
    ch_req = 3'b100;
    issue(2, 28'h7700, lat);
    ch_req = '0;
    for (int i = 0; i < 5; i++) begin
      tick();
      r_valid = 1'b1;
      r_data  = 16'($urandom) | 16'h1;
      exp_q.push_back('{en: 3'b100, data: r_data});
    end
    @(posedge clk);
    #1;
    chk("t6_pre_wr", 32'(fifo_wr_en), 32'h4);
    chk("t6_credit_pre", 32'(dut.credit[2]), 32'd496);
    rst_n = 1'b0;
    r_valid = 1'b0;
    exp_q.delete();
    #1;
    chk("t6_wr_en", 32'(fifo_wr_en), 32'h0);
    chk("t6_wr_data", 32'(fifo_wr_data), 32'h0);
    chk("t6_ar_valid", 32'(ar_valid), 32'h0);
    chk("t6_ar_addr", 32'(ar_addr), 32'h0);
    chk("t6_err", 32'(err), 32'h0);
    chk("t6_credit", 32'(dut.credit[2]), 32'd512);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      r_valid = 1'b1;
      r_last  = (i == 2);
      r_data  = 16'h00AA;
    end
    tick();
    r_valid = 1'b0;
    r_last  = 1'b0;
    tick();
    chk("t6_late_wr", 32'(fifo_wr_en), 32'h0);
    chk("t6_late_err", 32'(err), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rd_burst_arbiter.md
# rd_burst_arbiter

Read-burst scheduler that shares one DDR read command/data channel among NUM_CH video read streams, each draining into its own prefetch read-data FIFO (512 x 16). Issues fixed-length bursts round-robin, only when the target FIFO has guaranteed room (credit-based), and steers returning beats into the correct FIFO in issue order. Sits between the per-stream address generators and the DDR controller's read port, entirely in the DDR clock domain.

## Interface
Parameters:
- NUM_CH, 3, number of read streams / FIFOs
- ADDR_W, 28, burst address width
- DATA_W, 16, read data width (matches FIFO write width)
- FIFO_DEPTH, 512, words per channel FIFO
- BURST_LEN, 16, beats per burst (ar_len = BURST_LEN-1)
- OUTST_MAX, 4, max bursts in flight

Ports:
- clk  in  1  DDR-domain clock
- rst_n  in  1  asynchronous reset, active low
- ch_req  in  NUM_CH  channel wants a burst; level, held until ch_ack
- ch_addr  in  NUM_CH*ADDR_W  burst start address per channel; stable while ch_req
- ch_ack  out  NUM_CH  1-cycle pulse: command accepted by DDR
- ch_pop  in  NUM_CH  1-cycle pulse per word consumed from FIFO (already synchronized into clk)
- ar_valid  out  1  command valid
- ar_ready  in  1  command accepted
- ar_addr  out  ADDR_W  command address
- ar_len  out  8  constant BURST_LEN-1
- r_valid  in  1  read beat valid
- r_last  in  1  last beat of burst
- r_data  in  DATA_W  read beat
- r_ready  out  1  constant 1 (space pre-reserved)
- fifo_wr_en  out  NUM_CH  one-hot write strobe
- fifo_wr_data  out  DATA_W  shared write data
- err  out  2  sticky: [0] beat with empty tag queue, [1] r_last at wrong beat

## Operation
- Credit per channel, width clog2(FIFO_DEPTH)+1, resets to FIFO_DEPTH. Handshake (ar_valid&ar_ready) on channel c: credit -= BURST_LEN. ch_pop[c]: credit += 1. Both same cycle: net -BURST_LEN+1. Never exceeds FIFO_DEPTH (pop beyond is impossible by construction; saturate anyway).
- Eligible(c) = ch_req[c] & credit[c] >= BURST_LEN.
- FSM: IDLE -> CMD when any eligible & outstanding < OUTST_MAX; grant = first eligible after last granted (round-robin pointer, reset to NUM_CH-1 so ch0 wins first). CMD holds ar_valid/ar_addr stable until ar_ready, then pulses ch_ack[grant], pushes grant into tag queue, outstanding++, updates RR pointer, -> IDLE.
- ch_req dropping during CMD does not retract ar_valid; ack still pulses.
- Return: r_valid with tag queue non-empty -> fifo_wr_en[head]=1, fifo_wr_data=r_data (registered, 1 cycle). Beat counter per burst; r_last pops tag, outstanding--, counter clears. r_last at beat != BURST_LEN-1 sets err[1] (tag still popped). r_valid with empty queue: beat dropped, err[0] set.
- Tag push and pop in same cycle allowed; outstanding unchanged.
- Reset mid-operation: all state cleared; late beats from DDR after reset hit err[0].

## Timing
- Reset values: ar_valid 0, ar_addr 0, ch_ack 0, fifo_wr_en 0, fifo_wr_data 0, err 0, r_ready 1, ar_len BURST_LEN-1.
- ch_req (eligible, IDLE) -> ar_valid next cycle; ar_ready same-cycle handshake -> ch_ack next cycle -> back in IDLE; next command earliest 2 cycles after handshake.
- r_valid beat -> fifo_wr_en 1 cycle later; full-rate beats sustained.
- Credit reflects ch_pop of cycle N at cycle N+1 eligibility.

## Structure
- Package rd_arb_pkg: BURST_LEN, OUTST_MAX, FSM state enum, err bit indices.
- Sub-module rd_tag_queue: OUTST_MAX-deep FIFO of clog2(NUM_CH)-bit channel tags, simultaneous push/pop, empty/full flags.

## Test plan
- Single request ch1 addr 0x100, ar_ready tied 1 -> ar_valid one cycle after req, ch_ack[1] pulse, 16 beats land only on fifo_wr_en[1], credit[1]=496.
- All 3 channels requesting continuously -> grants ch0,ch1,ch2,ch0...; max 4 in flight, 5th waits for first r_last.
- ch2 with no pops -> exactly 32 bursts (512 words) issued, then ch2 stalls; 16 pops -> one more burst.
- ar_ready low 10 cycles -> ar_addr/ar_valid stable, no ack until ready, ch_req drop ignored.
- r_last on beat 9 -> err[1]=1, tag popped, next burst routes correctly; r_valid with no outstanding -> err[0]=1, no fifo_wr_en.
- rst_n low mid-burst -> all outputs to reset values immediately, credits back to 512.
